// File: rtl/vgauss5_column_filter.sv
// Vertical 5-tap Gaussian [1 4 6 4 1]/16 over one window column.
// Drops the upstream priming samples after clr, tags every accepted pixel
// with its frame position, and marks outputs whose full 5-row support lies
// inside the frame. Three enabled cycles from accepted sample to outputs.
module vgauss5_column_filter #(
  parameter int block_height = 5,
  parameter int pixel_depth  = 8,
  parameter int frame_width  = 640,
  parameter int frame_height = 480,
  parameter int in_lead      = 1
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                enable,
  input  logic [block_height*pixel_depth-1:0] Window,
  output logic [pixel_depth-1:0]              out_pix,
  output logic                                out_valid,
  output logic [9:0]                          out_x,
  output logic [9:0]                          out_y,
  output logic                                frame_done
);

  localparam int PAIR_W = pixel_depth + 1;  // sum of two pixels
  localparam int SUM_W  = pixel_depth + 4;  // weighted sum, max 16*(2^pd-1)
  localparam int LEAD_W = (in_lead > 0) ? $clog2(in_lead + 1) : 1;

  if (block_height != 5) begin : g_height_check
    $error("vgauss5_column_filter: block_height must be 5");
  end

  // Position tag travelling alongside the data through the pipeline.
  typedef struct packed {
    logic       live;  // an accepted sample, not a lead or idle bubble
    logic [9:0] x;
    logic [9:0] y;
    logic       last;  // bottom-right pixel of the frame
  } tag_t;

  // Column taps; slice 2 is the centre row of the kernel.
  logic [pixel_depth-1:0] p0, p1, p2, p3, p4;
  assign p0 = Window[0*pixel_depth +: pixel_depth];
  assign p1 = Window[1*pixel_depth +: pixel_depth];
  assign p2 = Window[2*pixel_depth +: pixel_depth];
  assign p3 = Window[3*pixel_depth +: pixel_depth];
  assign p4 = Window[4*pixel_depth +: pixel_depth];

  logic [LEAD_W-1:0] lead_cnt;
  logic              lead_done;
  logic              accept;
  logic [9:0]        x_cnt;
  logic [9:0]        y_cnt;
  logic              x_last;
  logic              y_last;

  assign lead_done = (lead_cnt == LEAD_W'(in_lead));
  assign accept    = enable && lead_done;
  assign x_last    = (x_cnt == 10'(frame_width - 1));
  assign y_last    = (y_cnt == 10'(frame_height - 1));

  // Count the enabled samples discarded while the upstream window primes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (clr) begin
      lead_cnt <= '0;
    end else if (enable && !lead_done) begin
      lead_cnt <= lead_cnt + 1'b1;
    end
  end

  // Raster position of the next accepted sample; x wraps into y, y wraps to 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? 10'd0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  // Pipeline registers.
  logic [PAIR_W-1:0]      s1_a;
  logic [PAIR_W-1:0]      s1_b;
  logic [pixel_depth-1:0] s1_c;
  tag_t                   s1_tag;
  logic [SUM_W-1:0]       s2_sum;
  tag_t                   s2_tag;

  logic [SUM_W-1:0] weighted;
  logic [SUM_W-1:0] rounded;

  // 1*(a) + 4*(b) + 6*c with shifts and adds only.
  assign weighted = SUM_W'(s1_a)
                  + (SUM_W'(s1_b) << 2)
                  + (SUM_W'(s1_c) << 2)
                  + (SUM_W'(s1_c) << 1);
  // Round half up before dividing by 16; the result always fits pixel_depth.
  assign rounded  = s2_sum + SUM_W'(8);

  // Three-stage filter pipeline: pair sums, weighted sum, rounded output.
  always_ff @(posedge clk) begin
    // NOTE: the pipeline data registers are reset along with the control bits
    // so a clr leaves no stale pixel or position visible on the outputs.
    if (clr) begin
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      s1_tag     <= '0;
      s2_sum     <= '0;
      s2_tag     <= '0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else if (enable) begin
      s1_a        <= {1'b0, p0} + {1'b0, p4};
      s1_b        <= {1'b0, p1} + {1'b0, p3};
      s1_c        <= p2;
      s1_tag.live <= accept;
      s1_tag.x    <= x_cnt;
      s1_tag.y    <= y_cnt;
      s1_tag.last <= x_last && y_last;

      s2_sum      <= weighted;
      s2_tag      <= s1_tag;

      out_pix     <= rounded[SUM_W-1:4];
      out_valid   <= s2_tag.live && (s2_tag.y >= 10'd4);
      out_x       <= s2_tag.x;
      out_y       <= s2_tag.y - 10'd2;
      frame_done  <= s2_tag.live && s2_tag.last;
    end
  end

endmodule

// File: tb/tb_vgauss5_column_filter.sv
// Scoreboard bench for vgauss5_column_filter on a small 8x8 frame.
// The driver pushes expected outputs (value, position, frame_done, due cycle)
// as samples are issued; a monitor pops and compares whenever the DUT presents
// an enabled output, and checks that outputs hold while enable is low.
module tb_vgauss5_column_filter;

  localparam int FW   = 8;
  localparam int FH   = 8;
  localparam int LEAD = 1;
  localparam int PD   = 8;
  localparam int NTBL = 10;

  logic          clk = 1'b0;
  logic          clr;
  logic          enable;
  logic [5*PD-1:0] window;
  logic [PD-1:0] out_pix;
  logic          out_valid;
  logic [9:0]    out_x;
  logic [9:0]    out_y;
  logic          frame_done;

  vgauss5_column_filter #(
    .block_height(5),
    .pixel_depth (PD),
    .frame_width (FW),
    .frame_height(FH),
    .in_lead     (LEAD)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .enable    (enable),
    .Window    (window),
    .out_pix   (out_pix),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int x;
    int y;
    int done;
    int due;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference-model state: accepted samples since clr and lead still to drop.
  int acc_cnt   = 0;
  int lead_left = LEAD;

  // Monitor state.
  int   en_edges        = 0;
  bit   edge_en         = 1'b0;
  bit   edge_clr        = 1'b1;
  int   frame_valid_cnt = 0;
  int   done_cnt        = 0;
  logic [PD-1:0] snap_pix   = '0;
  logic          snap_valid = 1'b0;
  logic [9:0]    snap_x     = '0;
  logic [9:0]    snap_y     = '0;
  logic          snap_done  = 1'b0;

  logic [5*PD-1:0] tbl_win [NTBL];
  int              tbl_exp [NTBL];

  task automatic check(input string name, input logic [31:0] actual, input int expected);
    total++;
    if (actual !== 32'(expected)) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [5*PD-1:0] pack5(input int p0, input int p1, input int p2,
                                            input int p3, input int p4);
    return {8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  // Gaussian [1 4 6 4 1]/16 with round-half-up, straight from the kernel.
  function automatic int model_pix(input logic [5*PD-1:0] w);
    int p[5];
    for (int k = 0; k < 5; k++) p[k] = int'(w[k*PD +: PD]);
    return (p[0] + p[4] + 4 * (p[1] + p[3]) + 6 * p[2] + 8) / 16;
  endfunction

  function automatic logic [5*PD-1:0] rand_win();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Issue one cycle of stimulus; exp_pix < 0 means use the reference model.
  task automatic drive(input bit en, input logic [5*PD-1:0] win, input int exp_pix);
    int   x;
    int   y;
    exp_t e;
    clr    = 1'b0;
    enable = en;
    window = win;
    if (en) begin
      if (lead_left > 0) begin
        lead_left--;
      end else begin
        x = acc_cnt % FW;
        y = (acc_cnt / FW) % FH;
        if (y >= 4) begin
          e.pix  = (exp_pix < 0) ? model_pix(win) : exp_pix;
          e.x    = x;
          e.y    = y - 2;
          e.done = (x == FW - 1 && y == FH - 1) ? 1 : 0;
          e.due  = en_edges + 3;
          sb_q.push_back(e);
        end
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Apply clr for one edge, optionally with enable and data present.
  task automatic do_clr(input bit en, input logic [5*PD-1:0] win);
    clr    = 1'b1;
    enable = en;
    window = win;
    @(posedge clk);
    #1;
    sb_q.delete();
    acc_cnt   = 0;
    lead_left = LEAD;
    clr       = 1'b0;
    enable    = 1'b0;
    check("clr_out_pix",    32'(out_pix),    0);
    check("clr_out_valid",  32'(out_valid),  0);
    check("clr_out_x",      32'(out_x),      0);
    check("clr_out_y",      32'(out_y),      0);
    check("clr_frame_done", 32'(frame_done), 0);
  endtask

  // Classify each edge: reset, enabled advance, or hold.
  always @(posedge clk) begin
    edge_clr = clr;
    edge_en  = enable && !clr;
    if (edge_en) en_edges++;
  end

  // Monitor: compare presented outputs against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (edge_clr) begin
      frame_valid_cnt = 0;
    end else if (edge_en) begin
      if (out_valid) begin
        frame_valid_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got output x=%0d y=%0d pix=%0d, expected none",
                   out_x, out_y, out_pix);
        end else begin
          e = sb_q.pop_front();
          check("out_pix",    32'(out_pix),    e.pix);
          check("out_x",      32'(out_x),      e.x);
          check("out_y",      32'(out_y),      e.y);
          check("frame_done", 32'(frame_done), e.done);
          check("latency",    32'(en_edges),   e.due);
        end
        if (frame_done) begin
          check("valids_per_frame", 32'(frame_valid_cnt), FW * (FH - 4));
          frame_valid_cnt = 0;
        end
      end else begin
        check("done_without_valid", 32'(frame_done), 0);
        if (sb_q.size() > 0 && sb_q[0].due <= en_edges) begin
          e = sb_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid: got out_valid=0, expected output x=%0d y=%0d pix=%0d",
                   e.x, e.y, e.pix);
        end
      end
      if (frame_done) done_cnt++;
    end else begin
      check("hold_pix",   32'(out_pix),    32'(snap_pix));
      check("hold_valid", 32'(out_valid),  32'(snap_valid));
      check("hold_x",     32'(out_x),      32'(snap_x));
      check("hold_y",     32'(out_y),      32'(snap_y));
      check("hold_done",  32'(frame_done), 32'(snap_done));
    end
    snap_pix   = out_pix;
    snap_valid = out_valid;
    snap_x     = out_x;
    snap_y     = out_y;
    snap_done  = frame_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Hand-derived impulse and rounding cases.
    tbl_win[0] = pack5(0, 0, 16, 0, 0);       tbl_exp[0] = 6;
    tbl_win[1] = pack5(0, 16, 0, 0, 0);       tbl_exp[1] = 4;
    tbl_win[2] = pack5(16, 0, 0, 0, 0);       tbl_exp[2] = 1;
    tbl_win[3] = pack5(255, 255, 255, 255, 255); tbl_exp[3] = 255;
    tbl_win[4] = pack5(1, 0, 0, 0, 0);        tbl_exp[4] = 0;
    tbl_win[5] = pack5(0, 0, 2, 0, 0);        tbl_exp[5] = 1;
    tbl_win[6] = pack5(8, 0, 0, 0, 0);        tbl_exp[6] = 1;
    tbl_win[7] = pack5(0, 2, 0, 2, 0);        tbl_exp[7] = 1;
    tbl_win[8] = pack5(0, 0, 0, 16, 0);       tbl_exp[8] = 4;
    tbl_win[9] = pack5(0, 0, 0, 0, 16);       tbl_exp[9] = 1;

    // Power-on reset.
    clr    = 1'b1;
    enable = 1'b0;
    window = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_pix",    32'(out_pix),    0);
    check("reset_out_valid",  32'(out_valid),  0);
    check("reset_out_x",      32'(out_x),      0);
    check("reset_out_y",      32'(out_y),      0);
    check("reset_frame_done", 32'(frame_done), 0);
    acc_cnt   = 0;
    lead_left = LEAD;

    // Flat frame of 100s with continuous enable (lead sample first).
    for (int i = 0; i < LEAD + FW * FH; i++) drive(1'b1, pack5(100, 100, 100, 100, 100), 100);

    // Directed impulse / rounding frame.
    for (int i = 0; i < FW * FH; i++) drive(1'b1, tbl_win[i % NTBL], tbl_exp[i % NTBL]);

    // Two random frames with roughly 50% enable gaps.
    for (int i = 0; i < 2 * FW * FH; i++) begin
      for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) drive(1'b0, rand_win(), -1);
      drive(1'b1, rand_win(), -1);
    end

    // Run into the middle of a frame, stop just before x=3, y=5 is accepted.
    while ((acc_cnt % (FW * FH)) != 5 * FW + 3) drive(1'b1, rand_win(), -1);
    // clr with enable and data on the same edge, then again during the lead.
    do_clr(1'b1, rand_win());
    do_clr(1'b1, rand_win());

    // Full frame after restart, with occasional gaps.
    for (int i = 0; i < LEAD + FW * FH; i++) begin
      if ($urandom_range(3) == 0) drive(1'b0, rand_win(), -1);
      drive(1'b1, rand_win(), -1);
    end

    // Flush the final outputs with top-of-frame samples that yield no valids.
    for (int i = 0; i < 4; i++) drive(1'b1, rand_win(), -1);
    enable = 1'b0;
    @(negedge clk);
    #1;

    check("scoreboard_empty", 32'(sb_q.size()), 0);
    check("frame_done_count", 32'(done_cnt), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
